stream_downsize: RTL and testbench

- Wide-to-narrow stream converter; the downstream counterpart of the upsizer stage.
- Accepts one wide beat of T_DATA_RATIO lanes with per-lane keep and last.
- Emits the kept lanes as consecutive narrow beats, lowest lane index first.
- Sits at the output of the widened datapath and restores the native narrow stream, including packet boundaries.

---
 rtl/stream_pkg.sv | 15 +
 rtl/stream_lane_ffs.sv | 33 +++
 rtl/stream_downsize.sv | 98 +++++++++
 tb/tb_stream_downsize.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream width-conversion blocks.
//   clog2_min1 : lane-index width helper, never returns less than 1 bit
//   state_t    : two-state encoding used by the downsizer control FSM
package stream_pkg;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/stream_lane_ffs.sv
// Combinational find-first-set over a lane mask.
//   mask       : lane mask, bit 0 has highest priority
//   index      : index of the lowest set bit (0 when mask is empty)
//   any        : at least one bit set
//   single_bit : exactly one bit set
module stream_lane_ffs
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_RATIO = 2
) (
    input  logic [T_DATA_RATIO-1:0]              mask,
    output logic [clog2_min1(T_DATA_RATIO)-1:0]  index,
    output logic                                 any,
    output logic                                 single_bit
);

    localparam int unsigned IDX_W = clog2_min1(T_DATA_RATIO);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        for (int unsigned i = T_DATA_RATIO; i > 0; i--) begin
            if (mask[i-1]) begin
                index = IDX_W'(i - 1);
            end
        end
    end

    assign any        = |mask;
    // x & (x-1) clears the lowest set bit; zero afterwards means only one was set.
    assign single_bit = any && ((mask & (mask - T_DATA_RATIO'(1))) == '0);

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter. Takes one wide beat of T_DATA_RATIO lanes
// with a per-lane keep mask and a packet-last flag, and emits the kept lanes
// as consecutive narrow words, lowest lane first. m_last_o accompanies the
// final kept lane of a beat that carried s_last_i.
//   clk, rst_n            : clock, asynchronous active-low reset
//   s_data_i/keep/last    : wide input beat, handshake s_valid_i/s_ready_o
//   m_data_o/m_last_o     : narrow output word, handshake m_valid_o/m_ready_i
module stream_downsize
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 4,
    parameter int unsigned T_DATA_RATIO = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_DATA_RATIO-1:0]                   s_keep_i,
    input  logic                                      s_last_i,
    input  logic                                      s_valid_i,
    output logic                                      s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                   m_data_o,
    output logic                                      m_last_o,
    output logic                                      m_valid_o,
    input  logic                                      m_ready_i
);

    localparam int unsigned IDX_W = clog2_min1(T_DATA_RATIO);
    typedef logic [IDX_W-1:0] lane_idx_t;

    state_t                                  state_q, state_d;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] buf_q, buf_d;
    logic [T_DATA_RATIO-1:0]                 rem_q, rem_d;
    logic                                    last_q, last_d;
    logic                                    ready_en_q;

    lane_idx_t ffs_idx;
    logic      ffs_any;
    logic      ffs_single;
    logic      final_word;

    stream_lane_ffs #(
        .T_DATA_RATIO (T_DATA_RATIO)
    ) u_ffs (
        .mask       (rem_q),
        .index      (ffs_idx),
        .any        (ffs_any),
        .single_bit (ffs_single)
    );

    // ready_en_q holds s_ready_o low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            rem_q      <= '0;
            last_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            rem_q      <= rem_d;
            last_q     <= last_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        last_d  = last_q;

        m_valid_o  = (state_q == ST_SEND);
        m_data_o   = (m_valid_o && ffs_any) ? buf_q[ffs_idx] : '0;
        m_last_o   = m_valid_o & last_q & ffs_single;
        final_word = m_valid_o & m_ready_i & ffs_single;

        // Accept in IDLE, or in the cycle the final word leaves so that a
        // following beat loads without a bubble.
        s_ready_o = ready_en_q & ((state_q == ST_IDLE) | final_word);

        if (m_valid_o && m_ready_i) begin
            rem_d = rem_q & (rem_q - T_DATA_RATIO'(1));
            if (final_word) begin
                state_d = ST_IDLE;
            end
        end

        // A zero-keep beat is consumed with no effect, so state_d stays IDLE.
        if (s_valid_i && s_ready_o && (|s_keep_i)) begin
            buf_d   = s_data_i;
            rem_d   = s_keep_i;
            last_d  = s_last_i;
            state_d = ST_SEND;
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
module tb_stream_downsize;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Ratio-2 instance
    logic [1:0][3:0] s2_data;
    logic [1:0]      s2_keep;
    logic            s2_last, s2_valid, s2_ready;
    logic [3:0]      m2_data;
    logic            m2_last, m2_valid, m2_ready;

    // Ratio-4 instance
    logic [3:0][3:0] s4_data;
    logic [3:0]      s4_keep;
    logic            s4_last, s4_valid, s4_ready;
    logic [3:0]      m4_data;
    logic            m4_last, m4_valid, m4_ready;

    int n_checks = 0;
    int n_errors = 0;

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s2_data), .s_keep_i(s2_keep), .s_last_i(s2_last),
        .s_valid_i(s2_valid), .s_ready_o(s2_ready),
        .m_data_o(m2_data), .m_last_o(m2_last), .m_valid_o(m2_valid),
        .m_ready_i(m2_ready)
    );

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s4_data), .s_keep_i(s4_keep), .s_last_i(s4_last),
        .s_valid_i(s4_valid), .s_ready_o(s4_ready),
        .m_data_o(m4_data), .m_last_o(m4_last), .m_valid_o(m4_valid),
        .m_ready_i(m4_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check ratio-2 output side and s_ready in one call.
    task automatic chk2(input string tag, input logic v, input logic [3:0] d,
                        input logic l, input logic r);
        chk({tag, ".valid"}, 32'(m2_valid), 32'(v));
        if (v) begin
            chk({tag, ".data"}, 32'(m2_data), 32'(d));
            chk({tag, ".last"}, 32'(m2_last), 32'(l));
        end
        chk({tag, ".s_ready"}, 32'(s2_ready), 32'(r));
    endtask

    task automatic chk4(input string tag, input logic v, input logic [3:0] d,
                        input logic l, input logic r);
        chk({tag, ".valid"}, 32'(m4_valid), 32'(v));
        if (v) begin
            chk({tag, ".data"}, 32'(m4_data), 32'(d));
            chk({tag, ".last"}, 32'(m4_last), 32'(l));
        end
        chk({tag, ".s_ready"}, 32'(s4_ready), 32'(r));
    endtask

    // Advance to the next falling edge; inputs change there, checks follow #1.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        s2_data = '0; s2_keep = '0; s2_last = 1'b0; s2_valid = 1'b0; m2_ready = 1'b1;
        s4_data = '0; s4_keep = '0; s4_last = 1'b0; s4_valid = 1'b0; m4_ready = 1'b1;

        // Reset state
        repeat (2) step();
        #1;
        chk("rst.m_valid", 32'(m2_valid), 0);
        chk("rst.m_last",  32'(m2_last),  0);
        chk("rst.m_data",  32'(m2_data),  0);
        chk("rst.s_ready", 32'(s2_ready), 0);
        rst_n = 1'b1;
        step(); #1;
        chk("rst_rel.s_ready2", 32'(s2_ready), 1);
        chk("rst_rel.s_ready4", 32'(s4_ready), 1);

        // T1: full beat {B,A}, last=1
        s2_data = {4'hB, 4'hA}; s2_keep = 2'b11; s2_last = 1'b1; s2_valid = 1'b1;
        #1 chk2("t1.c0", 1'b0, 4'h0, 1'b0, 1'b1);
        step(); s2_valid = 1'b0;
        #1 chk2("t1.c1", 1'b1, 4'hA, 1'b0, 1'b0);
        step();
        #1 chk2("t1.c2", 1'b1, 4'hB, 1'b1, 1'b1);
        step();
        #1 chk2("t1.c3", 1'b0, 4'h0, 1'b0, 1'b1);

        // T2: back-to-back {2,1} last=0 then {4,3} last=1
        s2_data = {4'h2, 4'h1}; s2_keep = 2'b11; s2_last = 1'b0; s2_valid = 1'b1;
        #1 chk2("t2.c0", 1'b0, 4'h0, 1'b0, 1'b1);
        step(); s2_data = {4'h4, 4'h3}; s2_last = 1'b1;
        #1 chk2("t2.c1", 1'b1, 4'h1, 1'b0, 1'b0);
        step();
        #1 chk2("t2.c2", 1'b1, 4'h2, 1'b0, 1'b1);
        step(); s2_valid = 1'b0;
        #1 chk2("t2.c3", 1'b1, 4'h3, 1'b0, 1'b0);
        step();
        #1 chk2("t2.c4", 1'b1, 4'h4, 1'b1, 1'b1);
        step();
        #1 chk2("t2.c5", 1'b0, 4'h0, 1'b0, 1'b1);

        // T3: ratio 4, sparse keep 1010, data {D,C,B,A}
        s4_data = {4'hD, 4'hC, 4'hB, 4'hA}; s4_keep = 4'b1010; s4_last = 1'b1; s4_valid = 1'b1;
        #1 chk4("t3.c0", 1'b0, 4'h0, 1'b0, 1'b1);
        step(); s4_valid = 1'b0;
        #1 chk4("t3.c1", 1'b1, 4'hB, 1'b0, 1'b0);
        step();
        #1 chk4("t3.c2", 1'b1, 4'hD, 1'b1, 1'b1);
        step();
        #1 chk4("t3.c3", 1'b0, 4'h0, 1'b0, 1'b1);

        // T4: backpressure mid-beat on {6,5}; a new beat waits on s_valid
        s2_data = {4'h6, 4'h5}; s2_keep = 2'b11; s2_last = 1'b1; s2_valid = 1'b1;
        #1 chk2("t4.acc", 1'b0, 4'h0, 1'b0, 1'b1);
        step(); m2_ready = 1'b0; s2_data = {4'hF, 4'hE}; s2_last = 1'b0;
        #1 chk2("t4.h0", 1'b1, 4'h5, 1'b0, 1'b0);
        step();
        #1 chk2("t4.h1", 1'b1, 4'h5, 1'b0, 1'b0);
        step();
        #1 chk2("t4.h2", 1'b1, 4'h5, 1'b0, 1'b0);
        step(); m2_ready = 1'b1;
        #1 chk2("t4.r0", 1'b1, 4'h5, 1'b0, 1'b0);
        step(); m2_ready = 1'b0;
        #1 chk2("t4.fin_stall", 1'b1, 4'h6, 1'b1, 1'b0);
        step(); m2_ready = 1'b1;
        #1 chk2("t4.fin", 1'b1, 4'h6, 1'b1, 1'b1);
        step(); s2_valid = 1'b0;
        #1 chk2("t4.nx0", 1'b1, 4'hE, 1'b0, 1'b0);
        step();
        #1 chk2("t4.nx1", 1'b1, 4'hF, 1'b0, 1'b1);
        step();
        #1 chk2("t4.idle", 1'b0, 4'h0, 1'b0, 1'b1);

        // T5: zero-keep beat with last=1 is discarded; then keep=01 data 7
        s2_data = {4'h9, 4'h9}; s2_keep = 2'b00; s2_last = 1'b1; s2_valid = 1'b1;
        #1 chk2("t5.z", 1'b0, 4'h0, 1'b0, 1'b1);
        step(); s2_data = {4'h0, 4'h7}; s2_keep = 2'b01; s2_last = 1'b0;
        #1 chk2("t5.z1", 1'b0, 4'h0, 1'b0, 1'b1);
        step(); s2_valid = 1'b0;
        #1 chk2("t5.w", 1'b1, 4'h7, 1'b0, 1'b1);
        step();
        #1 chk2("t5.idle", 1'b0, 4'h0, 1'b0, 1'b1);

        // T6: reset after first word of {9,8}
        s2_data = {4'h9, 4'h8}; s2_keep = 2'b11; s2_last = 1'b1; s2_valid = 1'b1;
        step(); s2_valid = 1'b0;
        #1 chk2("t6.w0", 1'b1, 4'h8, 1'b0, 1'b0);
        step();
        #1 chk2("t6.w1", 1'b1, 4'h9, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6.async.valid", 32'(m2_valid), 0);
        chk("t6.async.last",  32'(m2_last),  0);
        chk("t6.async.data",  32'(m2_data),  0);
        step(); rst_n = 1'b1;
        #1 chk("t6.rel.s_ready", 32'(s2_ready), 0);
        step();
        #1 chk2("t6.post0", 1'b0, 4'h0, 1'b0, 1'b1);
        step();
        #1 chk2("t6.post1", 1'b0, 4'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
